// File: rtl/shifter_arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// shifter_arb_ctrl_if
//   One requester port of the shared-shifter arbiter: a command channel
//   (req_*) and a response channel (rsp_*).
//
//   Handshake semantics (both channels): a transfer happens at a rising clock
//   edge where valid && ready are both high. The source holds valid and its
//   payload stable until that edge; ready may depend combinationally on valid.
//
//   Ports / signals
//     req_valid  command valid           (client -> arbiter)
//     req_ready  command accepted        (arbiter -> client)
//     req_data   operand                 (client -> arbiter)
//     req_amt    shift amount            (client -> arbiter)
//     req_dir    0 = left, 1 = right     (client -> arbiter)
//     rsp_valid  result available        (arbiter -> client)
//     rsp_ready  client consumes result  (client -> arbiter)
//     rsp_data   shifted result          (arbiter -> client)
//
//   Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface shifter_arb_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_dir;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_data, req_amt, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shifter_arb_ctrl.sv
// ---------------------------------------------------------------------------
// shifter_arb_ctrl
//   Two-port arbiter/sequencer in front of one registered barrel shifter
//   (1-cycle latency). A command accepted from either port is issued to the
//   shifter, its result is captured and returned on the owner's response
//   channel. One operation is in flight at a time (IDLE->ISSUE->CAPT->RESP).
//
//   Ports
//     Clock, Reset   single clock (posedge), synchronous active-high reset
//     port0, port1   requester ports (shifter_arb_ctrl_if.slave)
//     sh_data_in     to shifter data_in
//     sh_shift_amt   to shifter shift_amt
//     sh_dir         to shifter dir (0 = left, 1 = right)
//     sh_data_out    from shifter, valid one cycle after sh_* are sampled
//     busy           high whenever the FSM is not in IDLE
//     dbg_state      current FSM state encoding
//
//   Configuration
//     SHIFT_ARB_FIXED_PRIO_EN  defined: port 0 always wins a tie (port 1 can
//                              starve). Undefined (default): round-robin.
// ---------------------------------------------------------------------------
module shifter_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    shifter_arb_ctrl_if.slave port0,
    shifter_arb_ctrl_if.slave port1,
    output logic [WIDTH-1:0] sh_data_in,
    output logic [AMT_W-1:0] sh_shift_amt,
    output logic             sh_dir,
    input  logic [WIDTH-1:0] sh_data_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    // The shifter drive registers double as the command register: they are
    // loaded on accept and simply hold afterwards.
    logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [AMT_W-1:0] cmd_amt_q, cmd_amt_d;
    logic             cmd_dir_q, cmd_dir_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    logic grant0, grant1;
    logic owner_rsp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            grant0 = port0.req_valid;
            grant1 = port1.req_valid && !port0.req_valid;
`else
            // On a tie, grant the port that did not win last time.
            grant0 = port0.req_valid && (!port1.req_valid || last_grant_q);
            grant1 = port1.req_valid && (!port0.req_valid || !last_grant_q);
`endif
        end
    end

    assign owner_rsp_ready = owner_q ? port1.rsp_ready : port0.rsp_ready;

    always_comb begin
        state_d    = state_q;
        cmd_data_d = cmd_data_q;
        cmd_amt_d  = cmd_amt_q;
        cmd_dir_d  = cmd_dir_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d    = ISSUE;
                    cmd_data_d = grant1 ? port1.req_data : port0.req_data;
                    cmd_amt_d  = grant1 ? port1.req_amt  : port0.req_amt;
                    cmd_dir_d  = grant1 ? port1.req_dir  : port0.req_dir;
                    owner_d    = grant1;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                    last_grant_d = grant1;
`endif
                end
            end
            // The shifter samples sh_* at the edge that ends ISSUE.
            ISSUE: state_d = CAPT;
            // Shifter output is valid during CAPT; capture it at its end.
            CAPT: begin
                rsp_data_d = sh_data_out;
                state_d    = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            cmd_data_q <= '0;
            cmd_amt_q  <= '0;
            cmd_dir_q  <= 1'b0;
            owner_q    <= 1'b0;
            rsp_data_q <= '0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cmd_data_q <= cmd_data_d;
            cmd_amt_q  <= cmd_amt_d;
            cmd_dir_q  <= cmd_dir_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Ready is masked during reset so nothing appears accepted.
    assign port0.req_ready = grant0 && !Reset;
    assign port1.req_ready = grant1 && !Reset;
    assign port0.rsp_valid = (state_q == RESP) && !owner_q;
    assign port1.rsp_valid = (state_q == RESP) && owner_q;
    assign port0.rsp_data  = rsp_data_q;
    assign port1.rsp_data  = rsp_data_q;

    assign sh_data_in   = cmd_data_q;
    assign sh_shift_amt = cmd_amt_q;
    assign sh_dir       = cmd_dir_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;

endmodule
